id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubble insertion
//
// Purpose:
//   Captures one decoded instruction per cycle into the execute stage. Source
//   operands are forwarded from EX/MEM (highest priority) or MEM/WB, falling
//   back to register-file data. A load sitting in this stage whose destination
//   is read by the instruction in decode raises load_use_hazard; the stage
//   then loads a bubble and counts it.
//
// Ports:
//   clock, reset_n             clock and asynchronous active-low reset
//   stall, flush               hold current contents / discard and load bubble
//   in_valid, in_*_addr        decode slot valid and register numbers (6 bit)
//   in_ctrl                    decoded control: bit0 load, bit1 reg-write
//   rs_data, rt_data           register-file read data for in_rs/in_rt
//   exmem_*, memwb_*           forwarding sources (write enable, rd, data)
//   out_valid, out_*_addr      registered instruction valid and addresses
//   out_ctrl, out_a, out_b     registered control and forwarded operands
//   load_use_hazard            combinational; upstream holds decode while high
//   bubble_count               saturating count of hazard bubbles
module id_ex_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [5:0]  in_rs_addr,
  input  logic [5:0]  in_rt_addr,
  input  logic [5:0]  in_rd_addr,
  input  logic [7:0]  in_ctrl,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exmem_write,
  input  logic [5:0]  exmem_rd_addr,
  input  logic [31:0] exmem_data,
  input  logic        memwb_write,
  input  logic [5:0]  memwb_rd_addr,
  input  logic [31:0] memwb_data,
  output logic        out_valid,
  output logic [5:0]  out_rs_addr,
  output logic [5:0]  out_rt_addr,
  output logic [5:0]  out_rd_addr,
  output logic [7:0]  out_ctrl,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic        load_use_hazard,
  output logic [15:0] bubble_count
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [15:0] bubble_cnt_q;

  // Register 0 is hard-wired, so a pending write to it must never be forwarded.
  always_comb begin
    fwd_a = rs_data;
    if (in_rs_addr != 6'd0 && exmem_write && exmem_rd_addr == in_rs_addr)
      fwd_a = exmem_data;
    else if (in_rs_addr != 6'd0 && memwb_write && memwb_rd_addr == in_rs_addr)
      fwd_a = memwb_data;
  end

  always_comb begin
    fwd_b = rt_data;
    if (in_rt_addr != 6'd0 && exmem_write && exmem_rd_addr == in_rt_addr)
      fwd_b = exmem_data;
    else if (in_rt_addr != 6'd0 && memwb_write && memwb_rd_addr == in_rt_addr)
      fwd_b = memwb_data;
  end

  // Load data is not available until after EX, so a dependent instruction in
  // decode must wait one cycle behind a bubble.
  always_comb begin
    load_use_hazard = out_valid && out_ctrl[0] && in_valid && (out_rd_addr != 6'd0) &&
                      ((out_rd_addr == in_rs_addr) || (out_rd_addr == in_rt_addr));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_rs_addr  <= 6'd0;
      out_rt_addr  <= 6'd0;
      out_rd_addr  <= 6'd0;
      out_ctrl     <= 8'd0;
      out_a        <= 32'd0;
      out_b        <= 32'd0;
      bubble_cnt_q <= 16'd0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_rs_addr <= 6'd0;
      out_rt_addr <= 6'd0;
      out_rd_addr <= 6'd0;
      out_ctrl    <= 8'd0;
      out_a       <= 32'd0;
      out_b       <= 32'd0;
    end else if (stall) begin
      // hold everything, including the bubble counter
    end else if (load_use_hazard) begin
      out_valid   <= 1'b0;
      out_rs_addr <= 6'd0;
      out_rt_addr <= 6'd0;
      out_rd_addr <= 6'd0;
      out_ctrl    <= 8'd0;
      out_a       <= 32'd0;
      out_b       <= 32'd0;
      if (bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end else begin
      out_valid   <= in_valid;
      out_rs_addr <= in_rs_addr;
      out_rt_addr <= in_rt_addr;
      out_rd_addr <= in_rd_addr;
      // An empty slot must never carry load or reg-write downstream.
      out_ctrl    <= in_valid ? in_ctrl : 8'd0;
      out_a       <= fwd_a;
      out_b       <= fwd_b;
    end
  end

  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall, flush, in_valid;
  logic [5:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [7:0]  in_ctrl;
  logic [31:0] rs_data, rt_data;
  logic        exmem_write, memwb_write;
  logic [5:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, load_use_hazard;
  logic [5:0]  out_rs_addr, out_rt_addr, out_rd_addr;
  logic [7:0]  out_ctrl;
  logic [31:0] out_a, out_b;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rd_addr(in_rd_addr), .in_ctrl(in_ctrl), .rs_data(rs_data), .rt_data(rt_data),
    .exmem_write(exmem_write), .exmem_rd_addr(exmem_rd_addr), .exmem_data(exmem_data),
    .memwb_write(memwb_write), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_rs_addr(out_rs_addr), .out_rt_addr(out_rt_addr),
    .out_rd_addr(out_rd_addr), .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b),
    .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
  );

  typedef struct {
    logic        v;
    logic [5:0]  rs, rt, rd;
    logic [7:0]  ctrl;
    logic [31:0] rsd, rtd;
    logic        exw;
    logic [5:0]  exrd;
    logic [31:0] exd;
    logic        mww;
    logic [5:0]  mwrd;
    logic [31:0] mwd;
    logic        ev;
    logic [7:0]  ec;
    logic [31:0] ea, eb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; in_valid = 0;
    in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0; in_ctrl = 0;
    rs_data = 0; rt_data = 0;
    exmem_write = 0; exmem_rd_addr = 0; exmem_data = 0;
    memwb_write = 0; memwb_rd_addr = 0; memwb_data = 0;
  endtask

  task automatic drive_instr(input logic v, input logic [5:0] rs, input logic [5:0] rt,
                             input logic [5:0] rd, input logic [7:0] ctrl);
    in_valid = v; in_rs_addr = rs; in_rt_addr = rt; in_rd_addr = rd; in_ctrl = ctrl;
  endtask

  // Puts a load to r7 in the stage, then presents a dependent instruction and
  // lets the bubble edge go by. Leaves the bench at a negedge after the bubble.
  task automatic load_use(input logic [15:0] exp_cnt, input string tag);
    @(negedge clock);
    drive_instr(1, 6'd1, 6'd2, 6'd7, 8'h03);
    @(negedge clock);
    drive_instr(1, 6'd4, 6'd7, 6'd9, 8'h02);
    #1 check({tag, " hazard high"}, 32'(load_use_hazard), 32'd1);
    @(negedge clock);
    check({tag, " bubble valid"}, 32'(out_valid), 32'd0);
    check({tag, " bubble count"}, 32'(bubble_count), 32'(exp_cnt));
    check({tag, " hazard low"}, 32'(load_use_hazard), 32'd0);
  endtask

  initial begin
    //         v  rs  rt  rd  ctrl  rsd           rtd           exw exrd exd           mww mwrd mwd           ev ec     ea            eb
    vecs[0] = '{1, 3,  2,  4,  8'h02, 32'd19,      32'd0,        0,  0,   32'h0,        0,  0,   32'h0,        1, 8'h02, 32'd19,       32'd0};
    vecs[1] = '{1, 5,  6,  8,  8'h06, 32'h11,      32'h22,       1,  5,   32'hAAAA0000, 1,  5,   32'h00005555, 1, 8'h06, 32'hAAAA0000, 32'h22};
    vecs[2] = '{1, 5,  6,  8,  8'h06, 32'h11,      32'h22,       0,  5,   32'hAAAA0000, 1,  5,   32'h00005555, 1, 8'h06, 32'h00005555, 32'h22};
    vecs[3] = '{1, 0,  0,  1,  8'h02, 32'd0,       32'h77,       1,  0,   32'hFFFFFFFF, 1,  0,   32'h5,        1, 8'h02, 32'd0,        32'h77};
    vecs[4] = '{1, 10, 9,  11, 8'h80, 32'hCAFE,    32'hBEEF,     1,  8,   32'hDEAD,     1,  9,   32'h12345678, 1, 8'h80, 32'hCAFE,     32'h12345678};
    vecs[5] = '{0, 12, 13, 14, 8'hFF, 32'h3,       32'h4,        0,  0,   32'h0,        0,  0,   32'h0,        0, 8'h00, 32'h3,        32'h4};
    vecs[6] = '{1, 20, 20, 21, 8'h02, 32'h1,       32'h2,        1,  20,  32'h600D,     1,  20,  32'hBAD,      1, 8'h02, 32'h600D,     32'h600D};

    idle_inputs();
    reset_n = 0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_ctrl", 32'(out_ctrl), 32'd0);
    check("reset out_a", out_a, 32'd0);
    check("reset out_b", out_b, 32'd0);
    check("reset bubble_count", 32'(bubble_count), 32'd0);
    check("reset hazard", 32'(load_use_hazard), 32'd0);
    @(negedge clock);
    reset_n = 1;

    // Table: capture, forwarding priority, register 0, empty slot
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      drive_instr(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ctrl);
      rs_data = vecs[i].rsd; rt_data = vecs[i].rtd;
      exmem_write = vecs[i].exw; exmem_rd_addr = vecs[i].exrd; exmem_data = vecs[i].exd;
      memwb_write = vecs[i].mww; memwb_rd_addr = vecs[i].mwrd; memwb_data = vecs[i].mwd;
      @(negedge clock);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ec));
      check($sformatf("vec%0d out_a", i), out_a, vecs[i].ea);
      check($sformatf("vec%0d out_b", i), out_b, vecs[i].eb);
      check($sformatf("vec%0d out_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      check($sformatf("vec%0d out_rs", i), 32'(out_rs_addr), 32'(vecs[i].rs));
    end
    idle_inputs();

    // Load-use bubble, then the held instruction goes through
    load_use(16'd1, "lu1");
    @(negedge clock);
    check("lu1 retry valid", 32'(out_valid), 32'd1);
    check("lu1 retry rt", 32'(out_rt_addr), 32'd7);

    // Flush coincident with hazard: bubble, no count
    @(negedge clock);
    drive_instr(1, 6'd1, 6'd2, 6'd7, 8'h03);
    @(negedge clock);
    drive_instr(1, 6'd7, 6'd3, 6'd9, 8'h02);
    flush = 1;
    #1 check("flush+hz hazard", 32'(load_use_hazard), 32'd1);
    @(negedge clock);
    flush = 0;
    check("flush+hz valid", 32'(out_valid), 32'd0);
    check("flush+hz count", 32'(bubble_count), 32'd1);

    // Stall coincident with hazard: everything holds
    drive_instr(1, 6'd1, 6'd2, 6'd7, 8'h03);
    rs_data = 32'h4242;
    @(negedge clock);
    drive_instr(1, 6'd7, 6'd3, 6'd9, 8'h02);
    stall = 1;
    @(negedge clock);
    check("stall+hz valid", 32'(out_valid), 32'd1);
    check("stall+hz rd", 32'(out_rd_addr), 32'd7);
    check("stall+hz ctrl", 32'(out_ctrl), 32'h03);
    check("stall+hz out_a", out_a, 32'h4242);
    check("stall+hz count", 32'(bubble_count), 32'd1);

    // Flush and stall together: flush wins
    flush = 1;
    @(negedge clock);
    flush = 0; stall = 0;
    check("flush+stall valid", 32'(out_valid), 32'd0);
    check("flush+stall ctrl", 32'(out_ctrl), 32'd0);

    // Stall alone with changed inputs: no change
    drive_instr(1, 6'd15, 6'd16, 6'd17, 8'h02);
    rs_data = 32'h1111; rt_data = 32'h2222;
    @(negedge clock);
    drive_instr(1, 6'd18, 6'd19, 6'd20, 8'h06);
    rs_data = 32'h3333; rt_data = 32'h4444;
    stall = 1;
    @(negedge clock);
    stall = 0;
    check("stall out_a", out_a, 32'h1111);
    check("stall out_b", out_b, 32'h2222);
    check("stall out_rd", 32'(out_rd_addr), 32'd17);

    // Asynchronous reset mid-run, then normal capture on first edge after release
    load_use(16'd2, "lu2");
    #2 reset_n = 0;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst out_a", out_a, 32'd0);
    check("async rst rt", 32'(out_rt_addr), 32'd0);
    check("async rst count", 32'(bubble_count), 32'd0);
    @(negedge clock);
    reset_n = 1;
    drive_instr(1, 6'd3, 6'd2, 6'd5, 8'h02);
    rs_data = 32'd77; rt_data = 32'd88;
    @(negedge clock);
    check("post rst valid", 32'(out_valid), 32'd1);
    check("post rst out_a", out_a, 32'd77);

    // Saturation: preload near the top, then drive real hazards across it
    idle_inputs();
    @(negedge clock);
    dut.bubble_cnt_q = 16'hFFFD;
    for (int k = 0; k < 4; k++) begin
      load_use((k == 0) ? 16'hFFFE : 16'hFFFF, $sformatf("sat%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
